song_sequencer: RTL and testbench

Top-level play controller for the LED-matrix rhythm game. It accepts a start request and a song choice from the debounced button front end and runs a 3-2-1 countdown. It then drives the song select and a step-enable pulse into the note loader, handles pause/resume and abort, and ends the run when the loader reports finish. It also keeps a saturating count of completed plays for the score display.

---
 rtl/song_sequencer.sv | 173 +++++++++++++++++
 tb/tb_song_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: play controller for the LED-matrix rhythm game.
// Runs a 3-2-1 countdown, then drives song select and step pulses into the
// note loader, handles pause/resume and abort, and counts completed plays.
// Optional feature macro: SONG_SEQ_PAUSE_EN enables pause/resume; when it is
// undefined, pause_btn is ignored and PAUSE can never be entered.
module song_sequencer #(
  parameter int TICK_DIV     = 50000,
  parameter int COUNT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [1:0] song_sel,
  input  logic       pause_btn,
  input  logic       abort_btn,
  input  logic       loader_finish,
  output logic [1:0] song,
  output logic       step,
  output logic [1:0] countdown,
  output logic [2:0] state,
  output logic       busy,
  output logic       song_done,
  output logic [7:0] play_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int CW = $clog2(COUNT_CYCLES);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [1:0]    songLatch_q, songLatch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    countdown_q, countdown_d;
  logic [1:0]    song_q, song_d;
  logic          step_q, step_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    playCnt_q, playCnt_d;
  logic          pauseReq;

`ifdef SONG_SEQ_PAUSE_EN
  assign pauseReq = pause_btn;
`else
  logic unusedPauseBtn;
  assign unusedPauseBtn = pause_btn;
  assign pauseReq       = 1'b0;
`endif

  // Next-state logic: sequencing, countdown timing, step divider and play counting
  always_comb begin
    state_d     = state_q;
    songLatch_d = songLatch_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    countdown_d = countdown_q;
    playCnt_d   = playCnt_q;
    step_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_btn && (song_sel != 2'd0)) begin
          songLatch_d = song_sel;
          countdown_d = 2'd3;
          cnt_d       = '0;
          state_d     = COUNT;
        end
      end
      COUNT: begin
        if (abort_btn) begin
          state_d     = IDLE;
          countdown_d = 2'd0;
          cnt_d       = '0;
        end else if (cnt_q == COUNT_LAST) begin
          cnt_d = '0;
          if (countdown_q == 2'd1) begin
            state_d     = PLAY;
            countdown_d = 2'd0;
            div_d       = '0;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PLAY: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (abort_btn) begin
          state_d = IDLE;
        end else if (loader_finish) begin
          state_d = DONE;
        end else if (pauseReq) begin
          state_d = PAUSE;
        end else if (div_q == DIV_LAST) begin
          step_d = 1'b1;
        end
      end
      PAUSE: begin
        if (abort_btn) begin
          state_d = IDLE;
        end else if (loader_finish) begin
          state_d = DONE;
        end else if (pauseReq) begin
          state_d = PLAY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // DONE always exits after one cycle, so this fires once per completed play
    if (state_d == DONE) begin
      done_d = 1'b1;
      if (playCnt_q != 8'd255) begin
        playCnt_d = playCnt_q + 8'd1;
      end
    end

    song_d = ((state_d == PLAY) || (state_d == PAUSE)) ? songLatch_d : 2'd0;
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      songLatch_q <= 2'd0;
      cnt_q       <= '0;
      div_q       <= '0;
      countdown_q <= 2'd0;
      song_q      <= 2'd0;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      playCnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      songLatch_q <= songLatch_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      countdown_q <= countdown_d;
      song_q      <= song_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      playCnt_q   <= playCnt_d;
    end
  end

  assign song      = song_q;
  assign step      = step_q;
  assign countdown = countdown_q;
  assign state     = state_q;
  assign busy      = busy_q;
  assign song_done = done_q;
  assign play_cnt  = playCnt_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Testbench for song_sequencer with TICK_DIV=4 and COUNT_CYCLES=5.
module tb_song_sequencer;

  localparam int TD = 4;
  localparam int CC = 5;
`ifdef SONG_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic [1:0] song_sel;
  logic       pause_btn;
  logic       abort_btn;
  logic       loader_finish;
  logic [1:0] song;
  logic       step;
  logic [1:0] countdown;
  logic [2:0] state;
  logic       busy;
  logic       song_done;
  logic [7:0] play_cnt;

  int total = 0;
  int bad = 0;
  int completions = 0;

  // Behavioural reference: mode numbers follow the published state encodings
  int mState, mSong, mElapsed, mActive, mCnt;
  bit mStep, mDone;

  song_sequencer #(.TICK_DIV(TD), .COUNT_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .song_sel(song_sel),
    .pause_btn(pause_btn), .abort_btn(abort_btn), .loader_finish(loader_finish),
    .song(song), .step(step), .countdown(countdown), .state(state),
    .busy(busy), .song_done(song_done), .play_cnt(play_cnt)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mState = 0; mSong = 0; mElapsed = 0; mActive = 0; mCnt = 0;
    mStep = 0; mDone = 0;
  endtask

  // One clock edge of the reference: elapsed countdown cycles and active play
  // edges are plain counters; a step follows every TD-th active play edge.
  task automatic modelEdge();
    mStep = 0;
    mDone = 0;
    case (mState)
      0: if (start_btn && song_sel != 2'd0) begin
        mSong = int'(song_sel); mElapsed = 0; mState = 1;
      end
      1: if (abort_btn) mState = 0;
      else begin
        mElapsed++;
        if (mElapsed == 3 * CC) begin mState = 2; mActive = 0; end
      end
      2: begin
        mActive++;
        if (abort_btn) mState = 0;
        else if (loader_finish) begin mState = 4; mDone = 1; if (mCnt < 255) mCnt++; end
        else if (pause_btn && PAUSE_EN) mState = 3;
        else if (mActive % TD == 0) mStep = 1;
      end
      3: begin
        if (abort_btn) mState = 0;
        else if (loader_finish) begin mState = 4; mDone = 1; if (mCnt < 255) mCnt++; end
        else if (pause_btn && PAUSE_EN) mState = 2;
      end
      default: mState = 0;
    endcase
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic pulseStart(input logic [1:0] sel);
    song_sel = sel; start_btn = 1'b1;
    applyStimulus();
    start_btn = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    total++;
    if ({song, step, countdown, state, busy, song_done, play_cnt} !== 17'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h want 0", {song, step, countdown, state, busy, song_done, play_cnt});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
  endtask

  task automatic test_countdown();
    pulseStart(2'd1);
    for (int k = 1; k <= 3 * CC; k++) begin
      total++;
      if (state !== 3'd1 || countdown !== 2'(3 - (k - 1) / CC)) begin
        bad++;
        $display("[TB] FAIL countdown k=%0d: got state=%0d cd=%0d want state=1 cd=%0d", k, state, countdown, 3 - (k - 1) / CC);
      end
      applyStimulus();
    end
    for (int c = 1; c <= 13; c++) begin
      total++;
      if (state !== 3'd2 || song !== 2'd1 || step !== (c == 5 || c == 9 || c == 13)) begin
        bad++;
        $display("[TB] FAIL play_step c=%0d: got state=%0d song=%0d step=%0b", c, state, song, step);
      end
      applyStimulus();
    end
  endtask

  task automatic test_finish();
    loader_finish = 1'b1;
    applyStimulus();
    loader_finish = 1'b0;
    completions++;
    total++;
    if (state !== 3'd4 || song_done !== 1'b1 || song !== 2'd0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL done_cycle: got state=%0d done=%0b song=%0d busy=%0b want 4 1 0 1", state, song_done, song, busy);
    end
    applyStimulus();
    total++;
    if (state !== 3'd0 || song_done !== 1'b0 || song !== 2'd0 || play_cnt !== 8'(completions)) begin
      bad++;
      $display("[TB] FAIL after_done: got state=%0d done=%0b song=%0d cnt=%0d want 0 0 0 %0d", state, song_done, song, play_cnt, completions);
    end
  endtask

  task automatic test_ignore_start();
    pulseStart(2'd0);
    total++;
    if (state !== 3'd0 || busy !== 1'b0 || song !== 2'd0) begin
      bad++;
      $display("[TB] FAIL start_sel0: got state=%0d busy=%0b song=%0d want 0 0 0", state, busy, song);
    end
    pulseStart(2'd2);
    pulseStart(2'd3);
    song_sel = 2'd1;
    repeat (3 * CC - 1) applyStimulus();
    total++;
    if (state !== 3'd2 || song !== 2'd2) begin
      bad++;
      $display("[TB] FAIL latched_song: got state=%0d song=%0d want 2 2", state, song);
    end
    abort_btn = 1'b1;
    applyStimulus();
    abort_btn = 1'b0;
  endtask

  task automatic test_pause();
    pulseStart(2'd3);
    repeat (3 * CC) applyStimulus();
    repeat (5) applyStimulus();
    pause_btn = 1'b1;
    applyStimulus();
    pause_btn = 1'b0;
`ifdef SONG_SEQ_PAUSE_EN
    for (int i = 1; i <= 10; i++) begin
      total++;
      if (state !== 3'd3 || step !== 1'b0 || song !== 2'd3) begin
        bad++;
        $display("[TB] FAIL paused i=%0d: got state=%0d step=%0b song=%0d want 3 0 3", i, state, step, song);
      end
      if (i == 10) pause_btn = 1'b1;
      applyStimulus();
      pause_btn = 1'b0;
    end
    for (int r = 1; r <= 3; r++) begin
      total++;
      if (state !== 3'd2 || step !== (r == 3)) begin
        bad++;
        $display("[TB] FAIL resume r=%0d: got state=%0d step=%0b want 2 %0b", r, state, step, r == 3);
      end
      applyStimulus();
    end
`else
    for (int c = 7; c <= 13; c++) begin
      total++;
      if (state !== 3'd2 || step !== (c % TD == 1)) begin
        bad++;
        $display("[TB] FAIL nopause c=%0d: got state=%0d step=%0b want 2 %0b", c, state, step, c % TD == 1);
      end
      applyStimulus();
    end
`endif
    abort_btn = 1'b1;
    applyStimulus();
    abort_btn = 1'b0;
    total++;
    if (state !== 3'd0 || song_done !== 1'b0 || song !== 2'd0) begin
      bad++;
      $display("[TB] FAIL abort_play: got state=%0d done=%0b song=%0d", state, song_done, song);
    end
  endtask

  task automatic test_abort();
    pulseStart(2'd1);
    repeat (3 * CC) applyStimulus();
    abort_btn = 1'b1; loader_finish = 1'b1;
    applyStimulus();
    abort_btn = 1'b0; loader_finish = 1'b0;
    total++;
    if (state !== 3'd0 || song_done !== 1'b0 || play_cnt !== 8'(completions)) begin
      bad++;
      $display("[TB] FAIL abort_finish: got state=%0d done=%0b cnt=%0d want 0 0 %0d", state, song_done, play_cnt, completions);
    end
    applyStimulus();
    total++;
    if (song_done !== 1'b0 || play_cnt !== 8'(completions)) begin
      bad++;
      $display("[TB] FAIL abort_finish_late: got done=%0b cnt=%0d", song_done, play_cnt);
    end
    pulseStart(2'd2);
    repeat (3) applyStimulus();
    abort_btn = 1'b1;
    applyStimulus();
    abort_btn = 1'b0;
    total++;
    if (state !== 3'd0 || countdown !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_count: got state=%0d cd=%0d busy=%0b want 0 0 0", state, countdown, busy);
    end
  endtask

  task automatic test_saturate();
    for (int run = 0; run < 256; run++) begin
      pulseStart(2'($urandom_range(3, 1)));
      repeat (3 * CC) applyStimulus();
      loader_finish = 1'b1;
      applyStimulus();
      loader_finish = 1'b0;
      applyStimulus();
      completions++;
      total++;
      if (play_cnt !== 8'((completions > 255) ? 255 : completions)) begin
        bad++;
        $display("[TB] FAIL play_cnt run=%0d: got %0d want %0d", run, play_cnt, (completions > 255) ? 255 : completions);
      end
    end
  endtask

  task automatic test_reset_midrun();
    pulseStart(2'd3);
    repeat (3 * CC + 2) applyStimulus();
    pause_btn = 1'b1;
    applyStimulus();
    pause_btn = 1'b0;
`ifdef SONG_SEQ_PAUSE_EN
    total++;
    if (state !== 3'd3) begin
      bad++;
      $display("[TB] FAIL enter_pause: got state=%0d want 3", state);
    end
`endif
    rst = 1'b1;
    #2;
    total++;
    if ({song, step, countdown, state, busy, song_done, play_cnt} !== 17'd0) begin
      bad++;
      $display("[TB] FAIL reset_midrun: got %h want 0", {song, step, countdown, state, busy, song_done, play_cnt});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    completions = 0;
    pulseStart(2'd2);
    total++;
    if (state !== 3'd1 || countdown !== 2'd3) begin
      bad++;
      $display("[TB] FAIL restart: got state=%0d cd=%0d want 1 3", state, countdown);
    end
    repeat (3 * CC) applyStimulus();
    total++;
    if (state !== 3'd2 || song !== 2'd2) begin
      bad++;
      $display("[TB] FAIL restart_play: got state=%0d song=%0d want 2 2", state, song);
    end
  endtask

  task automatic test_random();
    logic [16:0] got, want;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    for (int i = 0; i < 3000; i++) begin
      start_btn     = ($urandom_range(7) == 0);
      song_sel      = 2'($urandom_range(3));
      pause_btn     = ($urandom_range(9) == 0);
      abort_btn     = ($urandom_range(59) == 0);
      loader_finish = ($urandom_range(39) == 0);
      applyStimulus();
      want = {((mState == 2 || mState == 3) ? 2'(mSong) : 2'd0), mStep,
              ((mState == 1) ? 2'(3 - mElapsed / CC) : 2'd0), 3'(mState),
              (mState != 0), mDone, 8'(mCnt)};
      got = {song, step, countdown, state, busy, song_done, play_cnt};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL random i=%0d: got %h want %h", i, got, want);
      end
    end
    start_btn = 1'b0; pause_btn = 1'b0; abort_btn = 1'b0; loader_finish = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start_btn = 1'b0; song_sel = 2'd0;
    pause_btn = 1'b0; abort_btn = 1'b0; loader_finish = 1'b0;
    modelReset();
    test_reset();
    test_countdown();
    test_finish();
    test_ignore_start();
    test_pause();
    test_abort();
    test_saturate();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
